// File: rtl/axi_lite_protocol_monitor.sv
// Passive AXI4-Lite link checker: outstanding tracking, handshake stability, ordering and timeouts.
// Violations accumulate in sticky err_vec; first_err records the lowest rule index of the first firing cycle.
module axi_lite_protocol_monitor #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 1,
  parameter int TIMEOUT_CYCLES  = 15,
  parameter int CHECK_SLAVE     = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    err_clear,
  input  logic                    awvalid,
  input  logic                    awready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [2:0]              awprot,
  input  logic                    wvalid,
  input  logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    bvalid,
  input  logic                    bready,
  input  logic                    arvalid,
  input  logic                    arready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [2:0]              arprot,
  input  logic                    rvalid,
  input  logic                    rready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  output logic [8:0]              err_vec,
  output logic                    err_valid,
  output logic [3:0]              first_err,
  output logic [3:0]              wr_outstanding,
  output logic [3:0]              rd_outstanding
);

  localparam logic [3:0] MAX_C     = 4'(MAX_OUTSTANDING);
  localparam bit         TO_EN     = (TIMEOUT_CYCLES != 0);
  localparam int         TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [7:0] TO_LAST   = TO_LAST_I[7:0];

  // Channel index order: 0 AW, 1 W, 2 AR, 3 B, 4 R.
  logic [4:0] vld, rdy, hs, stall;
  assign vld   = {rvalid, bvalid, arvalid, wvalid, awvalid};
  assign rdy   = {rready, bready, arready, wready, awready};
  assign hs    = vld & rdy;
  assign stall = vld & ~rdy;

  logic                    armed_q;
  logic [4:0]              stall_q;
  logic                    b_rdy_q, r_rdy_q, b_hs_q, r_hs_q;
  logic [ADDR_WIDTH-1:0]   awaddr_q, araddr_q;
  logic [2:0]              awprot_q, arprot_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic [3:0]              aw_cnt_q, aw_cnt_d, w_cnt_q, w_cnt_d, rd_cnt_q, rd_cnt_d;
  logic                    aw_ovf, w_ovf, rd_ovf;
  logic [4:0][7:0]         st_tmr_q, st_tmr_d;
  logic [7:0]              wr_tmr_q, wr_tmr_d, rd_tmr_q, rd_tmr_d;
  logic [8:0]              err_vec_q, err_vec_d, viol;
  logic [3:0]              first_err_q, first_err_d;
  logic [3:0]              wr_pre;

  // Returns {overflow, next count}; a decrement at zero is ignored, an increment past MAX holds at MAX.
  function automatic logic [4:0] step_cnt(input logic [3:0] cnt, input logic inc, input logic dec);
    logic [4:0] nxt;
    nxt = {1'b0, cnt} + {4'd0, inc} - {4'd0, dec && (cnt != 4'd0)};
    if (nxt > {1'b0, MAX_C}) step_cnt = {1'b1, MAX_C};
    else                     step_cnt = {1'b0, nxt[3:0]};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] t);
    sat_inc = (t == 8'hff) ? t : t + 8'd1;
  endfunction

  function automatic logic [3:0] lowest(input logic [8:0] v);
    lowest = 4'd0;
    for (int i = 8; i >= 0; i--) if (v[i]) lowest = 4'(i);
  endfunction

  assign wr_pre = (aw_cnt_q < w_cnt_q) ? aw_cnt_q : w_cnt_q;

  always_comb begin
    {aw_ovf, aw_cnt_d} = step_cnt(aw_cnt_q, hs[0], hs[3]);
    {w_ovf,  w_cnt_d}  = step_cnt(w_cnt_q,  hs[1], hs[3]);
    {rd_ovf, rd_cnt_d} = step_cnt(rd_cnt_q, hs[2], hs[4]);

    viol    = '0;
    viol[0] = stall_q[0] && (!awvalid || awaddr != awaddr_q || awprot != awprot_q);
    viol[1] = stall_q[1] && (!wvalid || wdata != wdata_q || wstrb != wstrb_q);
    viol[2] = stall_q[2] && (!arvalid || araddr != araddr_q || arprot != arprot_q);
    viol[3] = (bvalid && (aw_cnt_q == 4'd0 || w_cnt_q == 4'd0)) || (stall_q[3] && !bvalid);
    viol[4] = (rvalid && rd_cnt_q == 4'd0) || (stall_q[4] && (!rvalid || rdata != rdata_q));
    viol[5] = aw_ovf | w_ovf | rd_ovf;

    for (int i = 0; i < 5; i++) begin
      st_tmr_d[i] = stall[i] ? sat_inc(st_tmr_q[i]) : 8'd0;
      if (TO_EN && stall[i] && st_tmr_q[i] == TO_LAST) viol[6] = 1'b1;
    end

    wr_tmr_d = (wr_pre == 4'd0 || hs[3]) ? 8'd0 : sat_inc(wr_tmr_q);
    rd_tmr_d = (rd_cnt_q == 4'd0 || hs[4]) ? 8'd0 : sat_inc(rd_tmr_q);
    viol[7]  = TO_EN && ((wr_pre != 4'd0 && !hs[3] && wr_tmr_q == TO_LAST) ||
                         (rd_cnt_q != 4'd0 && !hs[4] && rd_tmr_q == TO_LAST));

    // Ready falling in the same cycle a pending valid is seen, with no handshake in between.
    viol[8] = (b_rdy_q && !b_hs_q && bvalid && !bready) ||
              (r_rdy_q && !r_hs_q && rvalid && !rready);

    if (CHECK_SLAVE == 0) begin
      viol[3] = 1'b0;
      viol[4] = 1'b0;
      viol[8] = 1'b0;
    end
    if (!armed_q) viol = '0;

    err_vec_d   = (err_clear ? 9'd0 : err_vec_q) | viol;
    first_err_d = err_clear ? 4'd0 : first_err_q;
    if ((err_clear || err_vec_q == 9'd0) && viol != 9'd0) first_err_d = lowest(viol);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_q     <= 1'b0;
      stall_q     <= '0;
      b_rdy_q     <= 1'b0;
      r_rdy_q     <= 1'b0;
      b_hs_q      <= 1'b0;
      r_hs_q      <= 1'b0;
      awaddr_q    <= '0;
      awprot_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      araddr_q    <= '0;
      arprot_q    <= '0;
      rdata_q     <= '0;
      aw_cnt_q    <= '0;
      w_cnt_q     <= '0;
      rd_cnt_q    <= '0;
      st_tmr_q    <= '0;
      wr_tmr_q    <= '0;
      rd_tmr_q    <= '0;
      err_vec_q   <= '0;
      first_err_q <= '0;
    end else begin
      armed_q     <= 1'b1;
      stall_q     <= stall;
      b_rdy_q     <= bready;
      r_rdy_q     <= rready;
      b_hs_q      <= hs[3];
      r_hs_q      <= hs[4];
      awaddr_q    <= awaddr;
      awprot_q    <= awprot;
      wdata_q     <= wdata;
      wstrb_q     <= wstrb;
      araddr_q    <= araddr;
      arprot_q    <= arprot;
      rdata_q     <= rdata;
      aw_cnt_q    <= aw_cnt_d;
      w_cnt_q     <= w_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      st_tmr_q    <= st_tmr_d;
      wr_tmr_q    <= wr_tmr_d;
      rd_tmr_q    <= rd_tmr_d;
      err_vec_q   <= err_vec_d;
      first_err_q <= first_err_d;
    end
  end

  assign err_vec        = err_vec_q;
  assign err_valid      = |err_vec_q;
  assign first_err      = first_err_q;
  assign wr_outstanding = wr_pre;
  assign rd_outstanding = rd_cnt_q;

endmodule

// File: tb/tb_axi_lite_protocol_monitor.sv
// Bench for axi_lite_protocol_monitor: directed scenarios then random traffic, scored against
// a cycle-level rule model whose expected outputs are queued and compared by a separate monitor.
module tb_axi_lite_protocol_monitor;
  localparam int MAXO = 2;
  localparam int TO   = 4;

  logic        clk = 1'b0;
  logic        reset, err_clear;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [8:0]  err_vec;
  logic        err_valid;
  logic [3:0]  first_err, wr_outstanding, rd_outstanding;

  axi_lite_protocol_monitor #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MAXO),
    .TIMEOUT_CYCLES(TO), .CHECK_SLAVE(1)
  ) dut (
    .clk(clk), .reset(reset), .err_clear(err_clear),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .err_vec(err_vec), .err_valid(err_valid), .first_err(first_err),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] ev;
    logic [3:0] fe;
    logic       v;
    logic [3:0] wo;
    logic [3:0] ro;
  } exp_t;
  exp_t exp_q[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_aw, m_w, m_rd, m_wt, m_rt, m_fe;
  int         m_st[5];
  bit         m_armed;
  bit [8:0]   m_ev;
  bit [4:0]   p_stall;
  bit         p_brdy, p_rrdy, p_bhs, p_rhs;
  logic [31:0] p_awaddr, p_araddr, p_wdata, p_rdata;
  logic [2:0]  p_awprot, p_arprot;
  logic [3:0]  p_wstrb;

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Raw count after a cycle: decrement ignored at zero, may exceed MAXO (caller clamps and flags).
  function automatic int raw_next(input int c, input bit inc, input bit dec);
    return c + int'(inc) - ((dec && c > 0) ? 1 : 0);
  endfunction

  task automatic model_step();
    bit [4:0] vl, rd, hs, st;
    bit [8:0] v;
    bit       load;
    int       wo, ro, na, nw, nr;
    exp_t     e;
    vl = {rvalid, bvalid, arvalid, wvalid, awvalid};
    rd = {rready, bready, arready, wready, awready};
    hs = vl & rd;
    st = vl & ~rd;
    if (reset) begin
      m_aw = 0; m_w = 0; m_rd = 0; m_wt = 0; m_rt = 0; m_fe = 0; m_ev = 0; m_armed = 0;
      for (int i = 0; i < 5; i++) m_st[i] = 0;
      p_stall = 0; p_brdy = 0; p_rrdy = 0; p_bhs = 0; p_rhs = 0;
      p_awaddr = 0; p_araddr = 0; p_wdata = 0; p_rdata = 0;
      p_awprot = 0; p_arprot = 0; p_wstrb = 0;
    end else begin
      v  = 0;
      wo = min2(m_aw, m_w);
      ro = m_rd;
      na = raw_next(m_aw, hs[0], hs[3]);
      nw = raw_next(m_w,  hs[1], hs[3]);
      nr = raw_next(m_rd, hs[2], hs[4]);
      if (m_armed) begin
        v[0] = p_stall[0] && (!awvalid || awaddr != p_awaddr || awprot != p_awprot);
        v[1] = p_stall[1] && (!wvalid || wdata != p_wdata || wstrb != p_wstrb);
        v[2] = p_stall[2] && (!arvalid || araddr != p_araddr || arprot != p_arprot);
        v[3] = (bvalid && (m_aw == 0 || m_w == 0)) || (p_stall[3] && !bvalid);
        v[4] = (rvalid && m_rd == 0) || (p_stall[4] && (!rvalid || rdata != p_rdata));
        v[5] = (na > MAXO) || (nw > MAXO) || (nr > MAXO);
        for (int i = 0; i < 5; i++) if (st[i] && m_st[i] == TO - 1) v[6] = 1;
        v[7] = (wo > 0 && !hs[3] && m_wt == TO - 1) || (ro > 0 && !hs[4] && m_rt == TO - 1);
        v[8] = (p_brdy && !p_bhs && bvalid && !bready) || (p_rrdy && !p_rhs && rvalid && !rready);
      end
      m_aw = min2(na, MAXO);
      m_w  = min2(nw, MAXO);
      m_rd = min2(nr, MAXO);
      for (int i = 0; i < 5; i++) m_st[i] = st[i] ? min2(m_st[i] + 1, 255) : 0;
      m_wt = (wo == 0 || hs[3]) ? 0 : min2(m_wt + 1, 255);
      m_rt = (ro == 0 || hs[4]) ? 0 : min2(m_rt + 1, 255);
      load = err_clear || (m_ev == 0);
      if (err_clear) begin m_ev = 0; m_fe = 0; end
      m_ev = m_ev | v;
      if (load && v != 0) begin
        for (int i = 8; i >= 0; i--) if (v[i]) m_fe = i;
      end
      p_stall = st; p_brdy = bready; p_rrdy = rready; p_bhs = hs[3]; p_rhs = hs[4];
      p_awaddr = awaddr; p_araddr = araddr; p_wdata = wdata; p_rdata = rdata;
      p_awprot = awprot; p_arprot = arprot; p_wstrb = wstrb;
      m_armed = 1;
    end
    e.ev = m_ev;
    e.fe = 4'(m_fe);
    e.v  = (m_ev != 0);
    e.wo = 4'(min2(m_aw, m_w));
    e.ro = 4'(m_rd);
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("err_vec",        32'(err_vec),        32'(e.ev));
      chk("first_err",      32'(first_err),      32'(e.fe));
      chk("err_valid",      32'(err_valid),      32'(e.v));
      chk("wr_outstanding", 32'(wr_outstanding), 32'(e.wo));
      chk("rd_outstanding", 32'(rd_outstanding), 32'(e.ro));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    awvalid = 0; awready = 0; wvalid = 0; wready = 0; bvalid = 0; bready = 0;
    arvalid = 0; arready = 0; rvalid = 0; rready = 0; err_clear = 0;
  endtask

  initial begin
    reset = 1; idle();
    awaddr = 0; araddr = 0; wdata = 0; rdata = 0; awprot = 0; arprot = 0; wstrb = 0;
    tick(); tick();
    chk("reset_err_vec", 32'(err_vec), 0);
    chk("reset_rd_out",  32'(rd_outstanding), 0);
    reset = 0;
    tick();

    // 1: stable stalled AW, then W and B
    awvalid = 1; awaddr = 32'h100; awprot = 3'd2;
    repeat (3) tick();
    awready = 1; tick();
    idle(); tick();
    chk("t1_err_vec", 32'(err_vec), 0);
    chk("t1_wr_out_pre_w", 32'(wr_outstanding), 0);
    wvalid = 1; wready = 1; wdata = 32'hcafe_0001; wstrb = 4'hf; tick();
    idle(); chk("t1_wr_out_post_w", 32'(wr_outstanding), 1);
    bvalid = 1; bready = 1; tick();
    idle(); tick();
    chk("t1_wr_out_done", 32'(wr_outstanding), 0);

    // 2: awaddr changes while stalled
    awvalid = 1; awaddr = 32'h100; tick();
    awaddr = 32'h104; tick();
    chk("t2_err_vec", 32'(err_vec), 32'h001);
    chk("t2_first_err", 32'(first_err), 0);
    chk("t2_err_valid", 32'(err_valid), 1);
    awready = 1; tick();
    idle(); wvalid = 1; wready = 1; tick();
    idle(); bvalid = 1; bready = 1; tick();
    idle(); err_clear = 1; tick();
    idle();

    // 3: read overflow at MAX_OUTSTANDING=2
    arvalid = 1; arready = 1; araddr = 32'h200;
    tick(); chk("t3_rd_out1", 32'(rd_outstanding), 1);
    tick(); chk("t3_rd_out2", 32'(rd_outstanding), 2);
    tick(); chk("t3_rd_out3", 32'(rd_outstanding), 2);
    chk("t3_ovf_bit", 32'(err_vec[5]), 1);
    idle(); rvalid = 1; rready = 1; tick(); tick();
    idle(); chk("t3_rd_out_done", 32'(rd_outstanding), 0);
    err_clear = 1; tick(); idle();

    // 4: B before W, then same-cycle AW + B at aw_cnt 0
    awvalid = 1; awready = 1; tick();
    idle(); bvalid = 1; bready = 1; tick();
    idle(); chk("t4_b_early", 32'(err_vec), 32'h008);
    err_clear = 1; tick();
    idle(); awvalid = 1; awready = 1; bvalid = 1; bready = 1; tick();
    idle(); chk("t4_b_same_cycle", 32'(err_vec[3]), 1);
    wvalid = 1; wready = 1; tick();
    idle(); bvalid = 1; bready = 1; tick();
    idle(); err_clear = 1; tick(); idle();

    // 5: handshake timeout then response timeout
    arvalid = 1; araddr = 32'h300;
    repeat (3) tick();
    chk("t5_no_hs_to_yet", 32'(err_vec[6]), 0);
    tick();
    chk("t5_hs_timeout", 32'(err_vec[6]), 1);
    arready = 1; err_clear = 1; tick();
    idle(); repeat (3) tick();
    chk("t5_no_rsp_to_yet", 32'(err_vec[7]), 0);
    tick();
    chk("t5_rsp_timeout", 32'(err_vec[7]), 1);

    // 6: clear colliding with a W violation, then reset mid-burst
    wvalid = 1; wdata = 32'haaaa_0000; wstrb = 4'h3; tick();
    wdata = 32'h5555_0000; err_clear = 1; tick();
    err_clear = 0;
    chk("t6_err_vec", 32'(err_vec), 32'h002);
    chk("t6_first_err", 32'(first_err), 1);
    awvalid = 1; arvalid = 1; reset = 1; tick();
    chk("t6_rst_err_vec", 32'(err_vec), 0);
    chk("t6_rst_first_err", 32'(first_err), 0);
    chk("t6_rst_rd_out", 32'(rd_outstanding), 0);
    reset = 0; idle(); tick(); tick();

    // random traffic: stalled channels mostly hold payload, occasional glitches
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      err_clear = ($urandom_range(0, 7) == 0);
      if (!(awvalid && !awready) || $urandom_range(0, 9) == 0) begin
        awvalid = 1'($urandom_range(0, 1));
        awaddr  = 32'($urandom_range(0, 3)) << 2;
        awprot  = 3'($urandom_range(0, 1));
      end
      if (!(wvalid && !wready) || $urandom_range(0, 9) == 0) begin
        wvalid = 1'($urandom_range(0, 1));
        wdata  = 32'($urandom_range(0, 3));
        wstrb  = 4'($urandom_range(14, 15));
      end
      if (!(arvalid && !arready) || $urandom_range(0, 9) == 0) begin
        arvalid = 1'($urandom_range(0, 1));
        araddr  = 32'($urandom_range(0, 3)) << 2;
        arprot  = 3'($urandom_range(0, 1));
      end
      if (!(bvalid && !bready) || $urandom_range(0, 9) == 0) bvalid = 1'($urandom_range(0, 1));
      if (!(rvalid && !rready) || $urandom_range(0, 9) == 0) begin
        rvalid = 1'($urandom_range(0, 1));
        rdata  = 32'($urandom_range(0, 3));
      end
      awready = 1'($urandom_range(0, 1));
      wready  = 1'($urandom_range(0, 1));
      arready = 1'($urandom_range(0, 1));
      bready  = 1'($urandom_range(0, 1));
      rready  = 1'($urandom_range(0, 1));
      tick();
    end
    reset = 0; idle();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
